// File: rtl/dcache_req_port_arbiter.sv
// dcache_req_port_arbiter
// Shares the single data-cache controller request path among the PTW, load-unit
// and store-unit ports. Fixed priority PTW > LOAD > STORE, with a starvation
// counter that forces the store port to win after STARVE_LIMIT lost rounds.
// Only one transaction is outstanding at a time.
module dcache_req_port_arbiter #(
    parameter int NUM_PORTS    = 3,
    parameter int PLEN         = 34,
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_PORTS-1:0]      req_i,
    input  logic [NUM_PORTS-1:0]      we_i,
    input  logic [NUM_PORTS*PLEN-1:0] addr_i,
    input  logic [NUM_PORTS*XLEN-1:0] wdata_i,
    input  logic [NUM_PORTS*XLEN/8-1:0] be_i,
    input  logic [NUM_PORTS*2-1:0]    size_i,
    output logic [NUM_PORTS-1:0]      gnt_o,
    output logic [NUM_PORTS-1:0]      rvalid_o,
    output logic [XLEN-1:0]           rdata_o,
    output logic                      ctrl_req_o,
    output logic                      ctrl_we_o,
    output logic [PLEN-1:0]           ctrl_addr_o,
    output logic [XLEN-1:0]           ctrl_wdata_o,
    output logic [XLEN/8-1:0]         ctrl_be_o,
    output logic [1:0]                ctrl_size_o,
    input  logic                      ctrl_gnt_i,
    input  logic                      ctrl_rvalid_i,
    input  logic [XLEN-1:0]           ctrl_rdata_i,
    output logic [1:0]                owner_o,
    output logic                      busy_o
);

    localparam int BE_W  = XLEN / 8;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] PTW_PORT   = 2'd0;
    localparam logic [1:0] STORE_PORT = 2'd2;

    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    localparam logic [1:0] ARB_IDLE     = 2'd0;
    localparam logic [1:0] ARB_REQ      = 2'd1;
    localparam logic [1:0] ARB_WAIT_RSP = 2'd2;

    logic [1:0]       state_reg, state_next;
    logic [1:0]       owner_reg, owner_next;
    logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;

    logic [1:0] lowest_req;
    logic [1:0] winner;
    logic       owner_req;
    logic       gnt_fire;
    logic       rsp_fire;

    // Lowest-index requester; scanning downwards lets the lowest index overwrite.
    always_comb begin
        lowest_req = PTW_PORT;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                lowest_req = i[1:0];
            end
        end
    end

    // A store that has lost STARVE_LIMIT rounds overrides fixed priority.
    assign winner = ((starve_cnt_reg == STARVE_MAX) && req_i[STORE_PORT]) ? STORE_PORT : lowest_req;

    assign owner_req = req_i[owner_reg];

    // The controller only sees a request while the owning port still asks for it,
    // so a withdrawn request can never be granted in the abort cycle.
    assign ctrl_req_o = (state_reg == ARB_REQ) && owner_req;
    assign gnt_fire   = ctrl_req_o && ctrl_gnt_i;

    // Payload follows the registered owner.
    assign ctrl_we_o    = we_i[owner_reg];
    assign ctrl_addr_o  = addr_i[owner_reg * PLEN +: PLEN];
    assign ctrl_wdata_o = wdata_i[owner_reg * XLEN +: XLEN];
    assign ctrl_be_o    = be_i[owner_reg * BE_W +: BE_W];
    assign ctrl_size_o  = size_i[owner_reg * 2 +: 2];

    // Load data is routed either together with the grant (hit) or later while waiting.
    assign rsp_fire = (gnt_fire && !ctrl_we_o && ctrl_rvalid_i)
                   || ((state_reg == ARB_WAIT_RSP) && ctrl_rvalid_i);

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port_decode
            assign gnt_o[gi]    = gnt_fire && (owner_reg == 2'(gi));
            assign rvalid_o[gi] = rsp_fire && (owner_reg == 2'(gi));
        end
    endgenerate

    assign rdata_o = ctrl_rdata_i;
    assign owner_o = owner_reg;
    assign busy_o  = (state_reg != ARB_IDLE);

    // Next-state, owner latch and starvation bookkeeping.
    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        starve_cnt_next = starve_cnt_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (|req_i) begin
                    owner_next = winner;
                    state_next = ARB_REQ;
                    if (winner == STORE_PORT) begin
                        starve_cnt_next = '0;
                    end else if (req_i[STORE_PORT] && (starve_cnt_reg != STARVE_MAX)) begin
                        starve_cnt_next = starve_cnt_reg + 1'b1;
                    end
                end
            end
            ARB_REQ: begin
                if (!owner_req) begin
                    state_next = ARB_IDLE;
                end else if (ctrl_gnt_i) begin
                    if (ctrl_we_o || ctrl_rvalid_i) begin
                        state_next = ARB_IDLE;
                    end else begin
                        state_next = ARB_WAIT_RSP;
                    end
                end
            end
            ARB_WAIT_RSP: begin
                if (ctrl_rvalid_i) begin
                    state_next = ARB_IDLE;
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= ARB_IDLE;
            owner_reg      <= PTW_PORT;
            starve_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

endmodule
